keypad_digit_scanner: RTL and testbench

Upstream command source for `step_motor_drive`. Scans a 4x4 matrix keypad, synchronises and debounces the row inputs, and decodes keys. Digit keys 0–9 produce a held `digit` with a one-cycle `load` strobe; keys A/B set or clear `en`. All outputs connect directly to the `en`, `load` and `digit` inputs of `step_motor_drive`.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_tick_gen.sv | 28 ++
 rtl/keypad_digit_scanner.sv | 152 +++++++++++++++
 tb/tb_keypad_digit_scanner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key codes
// and the {row,col} to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } scan_state_t;

    localparam logic [3:0] KEY_A          = 4'hA;
    localparam logic [3:0] KEY_B          = 4'hB;
    localparam logic [3:0] KEY_LAST_DIGIT = 4'h9;

    // Entry [{row,col}]; '*' = E, '#' = F.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,   // row 3: *  0  #  D  (cols 3..0 listed high to low)
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1
        4'hA, 4'h3, 4'h2, 4'h1    // row 0
    };

    function automatic logic single_low(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        case (r)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV clocks,
// asserted while the counter sits at SCAN_DIV-1.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 40000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_digit_scanner.sv
// 4x4 keypad scanner: rotates one active-low column per tick, debounces a single
// pressed row, and turns accepted keys into digit/load strobes and the enable level.
module keypad_digit_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 40000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit,
    output logic       load,
    output logic       en
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS);

    logic          tick;
    logic [3:0]    rows_meta;
    logic [3:0]    rows_sync;
    scan_state_t   state, state_next;
    logic [CW-1:0] count, count_next, count_inc;
    logic [1:0]    col_idx, col_next;
    logic [1:0]    key_row, key_row_next;
    logic [1:0]    key_col, key_col_next;
    logic [3:0]    digit_next;
    logic          load_next;
    logic          en_next;
    logic          row_single;
    logic [1:0]    row_idx;
    logic [3:0]    key_code;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Synchroniser resets to "all released" so reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
        end
    end

    assign row_single = single_low(rows_sync);
    assign row_idx    = low_index(rows_sync);
    assign count_inc  = count + 1'b1;
    assign key_code   = KEYMAP[{key_row, key_col}];
    assign cols       = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            count   <= '0;
            col_idx <= 2'd0;
            key_row <= 2'd0;
            key_col <= 2'd0;
            digit   <= 4'd0;
            load    <= 1'b0;
            en      <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            col_idx <= col_next;
            key_row <= key_row_next;
            key_col <= key_col_next;
            digit   <= digit_next;
            load    <= load_next;
            en      <= en_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        col_next     = col_idx;
        key_row_next = key_row;
        key_col_next = key_col;
        digit_next   = digit;
        load_next    = 1'b0;
        en_next      = en;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (row_single) begin
                        key_row_next = row_idx;
                        key_col_next = col_idx;
                        count_next   = CW'(1);
                        state_next   = (DEBOUNCE_TICKS == 1) ? PRESSED : DEBOUNCE;
                    end else begin
                        col_next = col_idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (row_single && (row_idx == key_row)) begin
                        count_next = count_inc;
                        if (count_inc == DB_LAST) begin
                            state_next = PRESSED;
                        end
                    end else begin
                        state_next = SCAN;
                        col_next   = col_idx + 2'd1;
                    end
                end
            end
            PRESSED: begin
                state_next = RELEASE;
                count_next = '0;
                if (key_code <= KEY_LAST_DIGIT) begin
                    digit_next = key_code;
                    load_next  = 1'b1;
                end else if (key_code == KEY_A) begin
                    en_next = 1'b1;
                end else if (key_code == KEY_B) begin
                    en_next = 1'b0;
                end
            end
            RELEASE: begin
                // Any row low during release restarts the quiet count, so a held key never repeats.
                if (tick) begin
                    if (rows_sync == 4'hF) begin
                        if (count_inc == DB_LAST) begin
                            state_next = SCAN;
                            count_next = '0;
                            col_next   = col_idx + 2'd1;
                        end else begin
                            count_next = count_inc;
                        end
                    end else begin
                        count_next = '0;
                    end
                end
            end
            default: begin
                state_next = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_digit_scanner.sv
// Directed bench for keypad_digit_scanner with a keypad model driving rows from cols.
module tb_keypad_digit_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  digit;
    logic        load;
    logic        en;
    logic [15:0] keys;

    int checks;
    int errors;
    logic [3:0] exp_q[$];

    keypad_digit_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rows (rows),
        .cols (cols),
        .digit(digit),
        .load (load),
        .en   (en)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every load pulse must match the next expected digit.
    always @(negedge clk) begin
        if (load) begin
            check("load_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check("load_digit", {28'd0, digit}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_watch(input int n, output int first);
        first = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (load && first < 0) first = i;
        end
    endtask

    task automatic wait_col(input logic [3:0] pat, output bit ok);
        logic [3:0] prev;
        prev = cols;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (cols == pat && prev != pat) ok = 1'b1;
            prev = cols;
        end
    endtask

    initial begin
        int first;
        bit ok;
        bit saw_last_col;
        logic [3:0] exp_cols;

        checks = 0;
        errors = 0;
        keys   = 16'h0000;
        reset  = 1'b0;

        // Reset values and column rotation
        run(10);
        check("reset_cols", {28'd0, cols}, 32'h0000000E);
        check("reset_digit", {28'd0, digit}, 32'd0);
        check("reset_load", {31'd0, load}, 32'd0);
        check("reset_en", {31'd0, en}, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_cols = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("rotate_cols_%0d", k), {28'd0, cols}, {28'd0, exp_cols});
            @(negedge clk);
        end

        // Key 4 pressed as column 0 becomes active; held 60 clk
        wait_col(4'b1110, ok);
        check("key4_col0_seen", {31'd0, ok}, 32'd1);
        keys[4] = 1'b1;
        exp_q.push_back(4'd4);
        run_watch(60, first);
        check("key4_latency", first, 13);
        check("key4_digit", {28'd0, digit}, 32'd4);
        check("key4_single_load", exp_q.size(), 0);
        keys = 16'h0000;
        run_watch(40, first);
        check("key4_no_repeat", first, -1);

        // A sets enable, 7 loads, 7 again re-loads, B clears enable
        keys[3] = 1'b1;
        run(80);
        check("keyA_en", {31'd0, en}, 32'd1);
        keys = 16'h0000;
        run(40);
        keys[8] = 1'b1;
        exp_q.push_back(4'd7);
        run(80);
        check("key7_digit", {28'd0, digit}, 32'd7);
        check("key7_loaded", exp_q.size(), 0);
        keys = 16'h0000;
        run(40);
        keys[8] = 1'b1;
        exp_q.push_back(4'd7);
        run(80);
        check("key7_repeat_loaded", exp_q.size(), 0);
        keys = 16'h0000;
        run(40);
        keys[7] = 1'b1;
        run(80);
        check("keyB_en", {31'd0, en}, 32'd0);
        check("keyB_digit_held", {28'd0, digit}, 32'd7);
        keys = 16'h0000;
        run(40);

        // Bounce on key 9: one tick low, one tick high, then held
        wait_col(4'b1011, ok);
        check("key9_col2_seen", {31'd0, ok}, 32'd1);
        keys[10] = 1'b1;
        run_watch(4, first);
        check("key9_bounce_low_no_load", first, -1);
        keys[10] = 1'b0;
        run_watch(4, first);
        check("key9_bounce_high_no_load", first, -1);
        keys[10] = 1'b1;
        exp_q.push_back(4'd9);
        run_watch(40, first);
        check("key9_latency_after_bounce", first, 25);
        check("key9_digit", {28'd0, digit}, 32'd9);
        keys = 16'h0000;
        run(40);

        // Keys 1 and 4 share column 0: ignored until 4 is released
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        saw_last_col = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cols == 4'b0111) saw_last_col = 1'b1;
        end
        check("two_keys_scan_continues", {31'd0, saw_last_col}, 32'd1);
        check("two_keys_digit_held", {28'd0, digit}, 32'd9);
        keys[4] = 1'b0;
        exp_q.push_back(4'd1);
        run_watch(60, first);
        check("two_keys_release_load", {31'd0, first > 0}, 32'd1);
        check("key1_digit", {28'd0, digit}, 32'd1);
        keys = 16'h0000;
        run(40);

        // Reset while key 2 is held in release
        keys[3] = 1'b1;
        run(80);
        keys = 16'h0000;
        run(40);
        check("pre_reset_en", {31'd0, en}, 32'd1);
        keys[1] = 1'b1;
        exp_q.push_back(4'd2);
        run_watch(80, first);
        check("key2_loaded", {31'd0, first > 0}, 32'd1);
        check("key2_digit", {28'd0, digit}, 32'd2);
        run(10);
        reset = 1'b0;
        run(3);
        check("midreset_cols", {28'd0, cols}, 32'h0000000E);
        check("midreset_digit", {28'd0, digit}, 32'd0);
        check("midreset_load", {31'd0, load}, 32'd0);
        check("midreset_en", {31'd0, en}, 32'd0);
        reset = 1'b1;
        exp_q.push_back(4'd2);
        run_watch(40, first);
        check("key2_full_debounce_after_reset", first, 17);
        check("key2_digit_after_reset", {28'd0, digit}, 32'd2);
        keys = 16'h0000;
        run(40);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
